// File: rtl/mem_arb_pkg.sv
// Shared constants, FSM state type and id-width helper for the memory-access arbiter.
package mem_arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   function automatic int calc_idw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_arbiter_param_if.sv
// Request/release/grant bundle between the masters and the arbiter.
interface mem_arbiter_param_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = mem_arb_pkg::calc_idw(NUM_REQ)
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [IDW-1:0]     grant_id;
   logic               timeout;

   modport master (output req, done, input grant, grant_valid, grant_id, timeout);
   modport slave  (input req, done, output grant, grant_valid, grant_id, timeout);
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner search: first set request after start, wrapping, with one index masked.
// Fixed priority is the same search started just below index 0.
module mem_arb_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               mask_en,
   input  logic [IDW-1:0]     mask_idx,
   input  logic [IDW-1:0]     start,
   input  logic               mode,
   output logic               found,
   output logic [IDW-1:0]     winner
);
   logic [NUM_REQ-1:0] cand;
   logic [IDW-1:0]     idx;
   int                 base;

   always_comb begin
      cand = req;
      if (mask_en) cand[mask_idx] = 1'b0;
      base   = mode ? int'(start) : NUM_REQ - 1;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((base + k) % NUM_REQ);
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter_param.sv
// N-way memory arbiter, fixed or round-robin, grant held until done/req-drop/hold limit.
// Grant registered one edge after request; handoff to the next winner on the release edge.
module mem_arbiter_param
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MODE     = 0,
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_arbiter_param_if.slave bus
);
   localparam int IDW = calc_idw(NUM_REQ);
   localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   arb_state_t         state;
   logic [HCW-1:0]     hold_cnt;
   logic [IDW-1:0]     rr_ptr;
   logic [NUM_REQ-1:0] grant_r;
   logic               grant_valid_r;
   logic [IDW-1:0]     grant_id_r;
   logic               timeout_r;

   logic               owner_done, owner_req, hold_hit, rel;
   logic               found;
   logic [IDW-1:0]     winner;

   assign owner_done = bus.done[grant_id_r];
   assign owner_req  = bus.req[grant_id_r];
   assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD - 1));
   assign rel        = (state == BUSY) && (owner_done || !owner_req || hold_hit);

   mem_arb_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
      .req      (bus.req),
      .mask_en  (state == BUSY),
      .mask_idx (grant_id_r),
      .start    (rr_ptr),
      .mode     (MODE == ARB_RR),
      .found    (found),
      .winner   (winner)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         rr_ptr        <= IDW'(NUM_REQ - 1);
         grant_r       <= '0;
         grant_valid_r <= 1'b0;
         grant_id_r    <= '0;
         timeout_r     <= 1'b0;
      end else begin
         timeout_r <= 1'b0;
         if (state == IDLE || rel) begin
            // Only a pure hold-limit release is reported as a timeout.
            if (rel) timeout_r <= hold_hit && !owner_done && owner_req;
            if (found) begin
               state         <= BUSY;
               hold_cnt      <= '0;
               rr_ptr        <= winner;
               grant_r       <= ONE << winner;
               grant_valid_r <= 1'b1;
               grant_id_r    <= winner;
            end else begin
               state         <= IDLE;
               hold_cnt      <= '0;
               grant_r       <= '0;
               grant_valid_r <= 1'b0;
               grant_id_r    <= '0;
            end
         end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_valid = grant_valid_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.timeout     = timeout_r;
endmodule

// File: tb/tb_mem_arbiter_param.sv
// Four arbiter configurations share one stimulus stream, each checked against its own reference model.
module tb_mem_arbiter_param;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int NI  = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] req, done;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_arbiter_param_if #(.NUM_REQ(N)) b0 (), b1 (), b2 (), b3 ();
   assign b0.req = req; assign b0.done = done;
   assign b1.req = req; assign b1.done = done;
   assign b2.req = req; assign b2.done = done;
   assign b3.req = req; assign b3.done = done;

   mem_arbiter_param #(.NUM_REQ(N), .MODE(0), .MAX_HOLD(16)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
   mem_arbiter_param #(.NUM_REQ(N), .MODE(1), .MAX_HOLD(16)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   mem_arbiter_param #(.NUM_REQ(N), .MODE(0), .MAX_HOLD(4))  u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
   mem_arbiter_param #(.NUM_REQ(N), .MODE(1), .MAX_HOLD(0))  u3 (.clk(clk), .reset_n(reset_n), .bus(b3));

   logic [N-1:0]   g   [NI];
   logic           gv  [NI];
   logic [IDW-1:0] gid [NI];
   logic           to  [NI];
   assign g[0] = b0.grant; assign gv[0] = b0.grant_valid; assign gid[0] = b0.grant_id; assign to[0] = b0.timeout;
   assign g[1] = b1.grant; assign gv[1] = b1.grant_valid; assign gid[1] = b1.grant_id; assign to[1] = b1.timeout;
   assign g[2] = b2.grant; assign gv[2] = b2.grant_valid; assign gid[2] = b2.grant_id; assign to[2] = b2.timeout;
   assign g[3] = b3.grant; assign gv[3] = b3.grant_valid; assign gid[3] = b3.grant_id; assign to[3] = b3.timeout;

   // Model state: owner index (-1 = nobody), cycles the grant has been high, last winner.
   int m_owner [NI];
   int m_hold  [NI];
   int m_ptr   [NI];
   bit m_to    [NI];

   function automatic int mode_of(input int k);
      return k % 2;
   endfunction

   function automatic int maxhold_of(input int k);
      return (k == 2) ? 4 : (k == 3) ? 0 : 16;
   endfunction

   function automatic int pick(input int mode, input int ptr, input logic [N-1:0] r, input int mask);
      int i;
      for (int s = 1; s <= N; s++) begin
         i = (mode == 1) ? (ptr + s) % N : s - 1;
         if (r[i] && i != mask) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_owner[k] = -1; m_hold[k] = 0; m_ptr[k] = N - 1; m_to[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      int w, o, mh;
      bit by_done, by_drop, by_lim;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         m_to[k] = 1'b0;
         mh = maxhold_of(k);
         o  = m_owner[k];
         by_done = (o >= 0) && done[o];
         by_drop = (o >= 0) && !req[o];
         by_lim  = (o >= 0) && (mh != 0) && (m_hold[k] == mh);
         if (o < 0 || by_done || by_drop || by_lim) begin
            if (o >= 0) m_to[k] = by_lim && !by_done && !by_drop;
            w = pick(mode_of(k), m_ptr[k], req, o);
            if (w >= 0) begin
               m_owner[k] = w; m_hold[k] = 1; m_ptr[k] = w;
            end else begin
               m_owner[k] = -1; m_hold[k] = 0;
            end
         end else begin
            m_hold[k]++;
         end
      end
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[%0d] observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < NI; k++) begin
         chk("grant",       k, 32'(g[k]),   (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0);
         chk("grant_valid", k, 32'(gv[k]),  (m_owner[k] >= 0) ? 32'd1 : 32'd0);
         chk("grant_id",    k, 32'(gid[k]), (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0);
         chk("timeout",     k, 32'(to[k]),  32'(m_to[k]));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < NI; k++) begin
         chk({tag, "_grant"}, k, 32'(g[k]), 32'd0);
         chk({tag, "_gv"},    k, 32'(gv[k]), 32'd0);
         chk({tag, "_gid"},   k, 32'(gid[k]), 32'd0);
         chk({tag, "_to"},    k, 32'(to[k]), 32'd0);
      end
   endtask

   task automatic cyc(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_step();
         #1;
         check_model();
      end
   endtask

   initial begin
      // Reset with everyone requesting.
      reset_n = 1'b0; req = 4'b1111; done = 4'b0000;
      model_reset();
      #1 check_zero("reset");
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      for (int k = 0; k < NI; k++) chk("first_grant", k, 32'(g[k]), 32'h1);

      // Drain to idle, then fixed-priority no-preemption and done handoff.
      req = 4'b0000; cyc(2);
      req = 4'b1100; cyc(2);
      req = 4'b1110; cyc(2);
      done = 4'b0100; cyc(1);
      done = 4'b0000; cyc(2);

      // Round-robin rotation with done on alternate cycles.
      req = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         done = (i % 2 == 1) ? 4'b1111 : 4'b0000;
         cyc(1);
      end
      done = 4'b0000;

      // Hold limit: no done with two requesters.
      req = 4'b0000; cyc(2);
      req = 4'b0011; cyc(12);

      // Owner drops request -> handoff.
      req = 4'b0010; cyc(2);
      // Sole requester releases while still requesting -> idle gap, then re-grant.
      req = 4'b0000; cyc(2);
      req = 4'b0001; cyc(2);
      done = 4'b0001; cyc(1);
      done = 4'b0000; cyc(3);
      // Non-owner done ignored.
      req = 4'b0011; done = 4'b0010; cyc(2);
      done = 4'b0000; cyc(1);

      // Async reset in the middle of an ownership.
      req = 4'b0000; cyc(2);
      req = 4'b1000; cyc(3);
      reset_n = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      cyc(1);
      req = 4'b1111;
      reset_n = 1'b1;
      cyc(1);
      for (int k = 0; k < NI; k++) chk("post_reset_grant", k, 32'(g[k]), 32'h1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         req  = 4'($urandom);
         done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         cyc(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
